alu_exec_seq: RTL and testbench

Multi-cycle execute sequencer that sits directly upstream of the ALU/PSR pair. It accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal register file. It drives the ALU operand and one-hot select lines, evaluates a condition against the PSR flags, and writes the result back. It is the first block in the datapath that consumes flcnz.

---
 rtl/alu_exec_seq_pkg.sv | 82 ++++++++
 rtl/alu_exec_seq_regfile.sv | 40 ++++
 rtl/alu_exec_seq.sv | 146 ++++++++++++++
 tb/tb_alu_exec_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_seq_pkg.sv
// Shared encodings for the execute sequencer: opcodes, condition codes,
// one-hot ALU selects, PSR flag positions, FSM states and small decode helpers.
package alu_exec_seq_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CS = 3'd3;
  localparam logic [2:0] COND_CC = 3'd4;
  localparam logic [2:0] COND_NS = 3'd5;
  localparam logic [2:0] COND_LO = 3'd6;
  localparam logic [2:0] COND_FS = 3'd7;

  localparam logic [5:0] SEL_ADD  = 6'b100000;
  localparam logic [5:0] SEL_SUB  = 6'b010000;
  localparam logic [5:0] SEL_CMP  = 6'b001000;
  localparam logic [5:0] SEL_AND  = 6'b000100;
  localparam logic [5:0] SEL_OR   = 6'b000010;
  localparam logic [5:0] SEL_XOR  = 6'b000001;
  localparam logic [5:0] SEL_NONE = 6'b000000;

  localparam int FLG_F = 4;
  localparam int FLG_L = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic cond_eval(input logic [2:0] cond, input logic [4:0] flags);
    logic pass;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flags[FLG_Z];
      COND_NE: pass = ~flags[FLG_Z];
      COND_CS: pass = flags[FLG_C];
      COND_CC: pass = ~flags[FLG_C];
      COND_NS: pass = flags[FLG_N];
      COND_LO: pass = flags[FLG_L];
      COND_FS: pass = flags[FLG_F];
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  function automatic logic [5:0] op_sel(input logic [2:0] op);
    logic [5:0] sel;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_SUB:  sel = SEL_SUB;
      OP_CMP:  sel = SEL_CMP;
      OP_AND:  sel = SEL_AND;
      OP_OR:   sel = SEL_OR;
      OP_XOR:  sel = SEL_XOR;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // SUB and CMP present ~B; the ALU adds the carry-in that completes the negate.
  function automatic logic op_inv_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_exec_seq_regfile.sv
// NREG x DATA_W register file: two asynchronous operand read ports, an
// asynchronous debug read port and one synchronous write port.
module seq_regfile
  import alu_exec_seq_pkg::*;
#(
  parameter int RF_W    = DATA_W,
  parameter int RF_N    = NREG,
  parameter int RF_AW   = $clog2(RF_N)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_we,
  input  logic [RF_AW-1:0]  i_waddr,
  input  logic [RF_W-1:0]   i_wdata,
  input  logic [RF_AW-1:0]  i_raddr_a,
  output logic [RF_W-1:0]   o_rdata_a,
  input  logic [RF_AW-1:0]  i_raddr_b,
  output logic [RF_W-1:0]   o_rdata_b,
  input  logic [RF_AW-1:0]  i_dbg_addr,
  output logic [RF_W-1:0]   o_dbg_data
);

  logic [RF_W-1:0] r_mem [RF_N];

  // Storage: synchronous clear, single write port.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < RF_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Four-state execute sequencer ahead of the ALU/PSR: fetches operands from the
// register file, gates the ALU on the PSR condition and writes the result back.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int DATA_W = alu_exec_seq_pkg::DATA_W,
  parameter int NREG   = alu_exec_seq_pkg::NREG
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        flags_in,
  output logic              done,
  output logic              skipped,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            r_state;
  state_e            w_next;
  logic [15:0]       r_instr;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_result;
  logic              r_skip;

  logic [2:0]        w_op;
  logic [2:0]        w_cond;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rdata_d;
  logic [DATA_W-1:0] w_rdata_s;
  logic [DATA_W-1:0] w_exec_result;
  logic              w_cond_pass;
  logic              w_in_exec;
  logic              w_in_wb;
  logic              w_we;
  logic [1:0]        w_unused_rsvd;

  assign w_op          = r_instr[15:13];
  assign w_cond        = r_instr[12:10];
  assign w_unused_rsvd = r_instr[9:8];
  assign w_rd          = r_instr[7:4];
  assign w_rs          = r_instr[3:0];
  assign w_imm         = {{(DATA_W-4){w_rs[3]}}, w_rs};
  assign w_cond_pass   = cond_eval(w_cond, flags_in);

  seq_regfile #(
    .RF_W  (DATA_W),
    .RF_N  (NREG),
    .RF_AW (4)
  ) u_regfile (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (r_result),
    .i_raddr_a  (w_rd),
    .o_rdata_a  (w_rdata_d),
    .i_raddr_b  (w_rs),
    .o_rdata_b  (w_rdata_s),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          w_next = ST_READ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (w_cond_pass) begin
          w_next = ST_EXEC;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_EXEC: w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Result captured at the end of EXEC: MOV and LDI bypass the ALU.
  always_comb begin
    w_exec_result = alu_out;
    case (w_op)
      OP_MOV:  w_exec_result = r_opb;
      OP_LDI:  w_exec_result = w_imm;
      default: w_exec_result = alu_out;
    endcase
  end

  // State register and per-state latches; reset aborts any instruction in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_instr  <= 16'h0000;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_skip   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
          end
        end
        ST_READ: begin
          r_opa  <= w_rdata_d;
          r_opb  <= op_inv_b(w_op) ? ~w_rdata_s : w_rdata_s;
          r_skip <= ~w_cond_pass;
        end
        ST_EXEC: r_result <= w_exec_result;
        default: r_skip <= r_skip;
      endcase
    end
  end

  // Outputs are decoded from state and forced low while RESET is held.
  assign w_in_exec   = (r_state == ST_EXEC) && !RESET;
  assign w_in_wb     = (r_state == ST_WB) && !RESET;
  assign instr_ready = (r_state == ST_IDLE) && !RESET;
  assign alu_a       = w_in_exec ? r_opa : '0;
  assign alu_b       = w_in_exec ? r_opb : '0;
  assign alu_sel     = w_in_exec ? op_sel(w_op) : SEL_NONE;
  assign done        = w_in_wb;
  assign skipped     = w_in_wb && r_skip;
  assign w_we        = w_in_wb && !r_skip && (w_op != OP_CMP);

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: queue-based cycle model plus a simple
// external ALU, directed sequences with literal expectations, then random traffic.
module tb_alu_exec_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_sel;
  logic [15:0] alu_out;
  logic [4:0]  flags_in;
  logic        done;
  logic        skipped;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #5 CLK = ~CLK;

  alu_exec_seq dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .flags_in    (flags_in),
    .done        (done),
    .skipped     (skipped),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External ALU: SUB/CMP add the carry-in of 1.
  always_comb begin
    case (alu_sel)
      6'b100000: alu_out = alu_a + alu_b;
      6'b010000: alu_out = alu_a + alu_b + 16'd1;
      6'b001000: alu_out = alu_a + alu_b + 16'd1;
      6'b000100: alu_out = alu_a & alu_b;
      6'b000010: alu_out = alu_a | alu_b;
      6'b000001: alu_out = alu_a ^ alu_b;
      default:   alu_out = 16'hDEAD;
    endcase
  end

  typedef struct {
    bit        ready;
    bit        done;
    bit        skipped;
    bit [5:0]  sel;
    bit        chk_ab;
    bit [15:0] a;
    bit [15:0] b;
    bit        wr;
    bit [3:0]  wa;
    bit [15:0] wd;
  } exp_t;

  exp_t      q[$];
  bit [15:0] mr[16];
  bit        pending;
  bit [15:0] pend_instr;
  bit        rst_seen;
  int        n_tests;
  int        n_fail;
  int        n_accept;
  int        n_done;
  bit [15:0] last_a;
  bit [15:0] last_b;
  bit [5:0]  last_sel;
  bit        last_skip;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input bit [2:0] c, input bit [4:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[2];
      3'd4: return !f[2];
      3'd5: return f[1];
      3'd6: return f[3];
      default: return f[4];
    endcase
  endfunction

  // Expand an accepted instruction (evaluated in its operand-read cycle) into per-cycle expectations.
  task automatic expand(input bit [15:0] pi, input bit [4:0] fl);
    exp_t x;
    exp_t w;
    bit [2:0]  op;
    bit [3:0]  rd;
    bit [3:0]  rs;
    bit [15:0] va;
    bit [15:0] vb;
    bit [15:0] res;
    op = pi[15:13];
    rd = pi[7:4];
    rs = pi[3:0];
    va = mr[rd];
    vb = mr[rs];
    w = '{default: 0};
    w.done = 1'b1;
    if (!cond_ok(pi[12:10], fl)) begin
      w.skipped = 1'b1;
      q.push_back(w);
    end else begin
      x = '{default: 0};
      x.sel    = (op < 3'd6) ? (6'b100000 >> op) : 6'b000000;
      x.chk_ab = (op < 3'd6);
      x.a      = va;
      x.b      = (op == 3'd1 || op == 3'd2) ? ~vb : vb;
      case (op)
        3'd0: res = va + vb;
        3'd1: res = va - vb;
        3'd3: res = va & vb;
        3'd4: res = va | vb;
        3'd5: res = va ^ vb;
        3'd6: res = vb;
        3'd7: res = {{12{rs[3]}}, rs};
        default: res = va;
      endcase
      w.wr = (op != 3'd2);
      w.wa = rd;
      w.wd = res;
      q.push_back(x);
      q.push_back(w);
    end
  endtask

  // Single compare process, one pass per cycle on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      chk("rst_ready", instr_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_skipped", skipped, 0);
      chk("rst_sel", alu_sel, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      if (rst_seen) chk("rst_dbg", dbg_data, 0);
      q.delete();
      pending = 1'b0;
      for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (q.size() == 0) begin
        e = '{default: 0};
        e.ready = 1'b1;
        if (instr_valid) begin
          pend_instr = instr;
          pending = 1'b1;
          n_accept++;
          q.push_back('{default: 0});
        end
      end else begin
        e = q.pop_front();
        if (pending) begin
          expand(pend_instr, flags_in);
          pending = 1'b0;
        end
      end
      chk("ready", instr_ready, e.ready);
      chk("done", done, e.done);
      chk("skipped", skipped, e.skipped);
      chk("alu_sel", alu_sel, e.sel);
      if (e.chk_ab) begin
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
      end
      chk("dbg_data", dbg_data, mr[dbg_addr]);
      if (alu_sel != 6'b000000) begin
        last_a = alu_a;
        last_b = alu_b;
        last_sel = alu_sel;
      end
      if (done) begin
        last_skip = skipped;
        n_done++;
      end
      if (e.wr) mr[e.wa] = e.wd;
    end
  end

  function automatic bit [15:0] enc(input bit [2:0] op, input bit [2:0] c, input bit [3:0] rd, input bit [3:0] rs);
    return {op, c, 2'b00, rd, rs};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || pending) && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    n_tests++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL idle_timeout: model still busy after %0d cycles", n);
    end
  endtask

  task automatic run(input bit [15:0] ins, input bit [4:0] fl);
    wait_idle();
    instr = ins;
    flags_in = fl;
    dbg_addr = ins[7:4];
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reg(input string nm, input bit [3:0] addr, input bit [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int prev_acc;
    RESET = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    flags_in = 5'b00000;
    dbg_addr = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("ready_after_reset", instr_ready, 1);

    run(enc(3'd7, 3'd0, 4'd1, 4'd5), 5'b00000);
    check_reg("ldi_r1", 4'd1, 16'h0005);
    run(enc(3'd7, 3'd0, 4'd2, 4'hD), 5'b00000);
    check_reg("ldi_r2", 4'd2, 16'hFFFD);

    run(enc(3'd0, 3'd0, 4'd1, 4'd2), 5'b00000);
    chk("add_a", last_a, 16'h0005);
    chk("add_b", last_b, 16'hFFFD);
    chk("add_sel", last_sel, 6'b100000);
    check_reg("add_r1", 4'd1, 16'h0002);

    run(enc(3'd1, 3'd0, 4'd1, 4'd1), 5'b00000);
    chk("sub_b", last_b, 16'hFFFD);
    chk("sub_sel", last_sel, 6'b010000);
    check_reg("sub_r1", 4'd1, 16'h0000);

    run(enc(3'd2, 3'd0, 4'd2, 4'd2), 5'b00000);
    check_reg("cmp_r2", 4'd2, 16'hFFFD);
    run(enc(3'd6, 3'd1, 4'd3, 4'd2), 5'b00001);
    check_reg("moveq_r3", 4'd3, 16'hFFFD);
    nd = n_done;
    run(enc(3'd6, 3'd1, 4'd4, 4'd2), 5'b00000);
    chk("skip_flag", last_skip, 1);
    chk("skip_done", n_done - nd, 1);
    check_reg("skip_r4", 4'd4, 16'h0000);

    run(enc(3'd7, 3'd0, 4'd5, 4'd7), 5'b00000);
    run(enc(3'd0, 3'd0, 4'd5, 4'd5), 5'b00000);
    run(enc(3'd7, 3'd0, 4'd10, 4'd1), 5'b00000);
    run(enc(3'd0, 3'd0, 4'd5, 4'd10), 5'b00000);
    for (int i = 0; i < 4; i++) run(enc(3'd0, 3'd0, 4'd5, 4'd5), 5'b00000);
    check_reg("build_r5", 4'd5, 16'h00F0);
    run(enc(3'd6, 3'd0, 4'd6, 4'd5), 5'b00000);
    for (int i = 0; i < 4; i++) run(enc(3'd0, 3'd0, 4'd6, 4'd6), 5'b00000);
    run(enc(3'd0, 3'd0, 4'd6, 4'd5), 5'b00000);
    check_reg("build_r6", 4'd6, 16'h0FF0);
    run(enc(3'd6, 3'd0, 4'd7, 4'd5), 5'b00000);
    run(enc(3'd3, 3'd0, 4'd7, 4'd6), 5'b00000);
    check_reg("and_r7", 4'd7, 16'h00F0);
    run(enc(3'd6, 3'd0, 4'd8, 4'd5), 5'b00000);
    run(enc(3'd4, 3'd0, 4'd8, 4'd6), 5'b00000);
    check_reg("or_r8", 4'd8, 16'h0FF0);
    run(enc(3'd6, 3'd0, 4'd9, 4'd5), 5'b00000);
    run(enc(3'd5, 3'd0, 4'd9, 4'd6), 5'b00000);
    check_reg("xor_r9", 4'd9, 16'h0F00);

    // Reset in the middle of an ADD: no retirement, registers cleared.
    run(enc(3'd7, 3'd0, 4'd1, 4'd5), 5'b00000);
    wait_idle();
    nd = n_done;
    instr = enc(3'd0, 3'd0, 4'd1, 4'd2);
    dbg_addr = 4'd1;
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    @(posedge CLK); #1;
    chk("exec_sel_before_reset", alu_sel, 6'b100000);
    RESET = 1'b1;
    #1;
    chk("mid_rst_ready", instr_ready, 0);
    chk("mid_rst_sel", alu_sel, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    chk("mid_rst_ready_after", instr_ready, 1);
    chk("mid_rst_no_done", n_done - nd, 0);
    check_reg("mid_rst_r1", 4'd1, 16'h0000);
    check_reg("mid_rst_r2", 4'd2, 16'h0000);

    // Random traffic with instr_valid held high back to back.
    @(posedge CLK); #1;
    prev_acc = n_accept;
    instr = 16'($urandom);
    instr_valid = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      flags_in = 5'($urandom);
      dbg_addr = 4'($urandom);
      if (n_accept != prev_acc) begin
        prev_acc = n_accept;
        instr = 16'($urandom);
      end
      @(posedge CLK); #1;
    end
    instr_valid = 1'b0;
    wait_idle();
    chk("random_accepts_min", (n_accept - nd) > 200, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
